cpu_sequencer: RTL and testbench

Fetch/execute controller for the 16-bit CPU core. Owns the program counter, instruction register, inline data latch and conditional-skip state. Fetches each instruction as bytes over an 8-bit request/acknowledge memory port, then presents it to the instruction decoder for a single execute cycle. Applies branch and IF results from the decoder to sequence the next fetch.

---
 rtl/cpu_sequencer.sv | 159 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/execute controller for the 16-bit CPU core.
// Fetches instructions bytewise over a req/ack port, then runs one execute cycle.
// Optional feature macro: CPU_SINGLE_STEP_EN adds the step port and a HALT state.
module cpu_sequencer (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] inst,
    output logic [7:0]  data,
    output logic        dec_en,
    output logic        exec,
    output logic [15:0] pc,
    input  logic        inst_branch,
    input  logic        inst_if,
    input  logic        if_zero,
    input  logic        if_not_zero,
    input  logic        if_else,
    input  logic        if_not_else,
    input  logic [15:0] rhs,
    input  logic        acc_zero
`ifdef CPU_SINGLE_STEP_EN
    ,
    input  logic        step
`endif
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned INST_W = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        S_FETCH_HI   = 3'd0,
        S_FETCH_LO   = 3'd1,
        S_FETCH_DATA = 3'd2,
        S_EXEC       = 3'd3,
        S_HALT       = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic                skip_q, skip_d;
    logic                else_q, else_d;
    logic                mem_req_q, mem_req_d;
    logic                exec_c;
    logic                xfer_c;
    logic                has_data_c;

    // A byte transfer completes only while a request is actually outstanding
    assign xfer_c     = mem_req_q && mem_ack;
    // Data-operand class is decoded from the high IR byte loaded in FETCH_HI
    assign has_data_c = (inst_q[15:14] == 2'b10) && (inst_q[10:9] == 2'b01);

    // Next-state, register updates and execute strobe
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        data_d    = data_q;
        skip_d    = skip_q;
        else_d    = else_q;
        exec_c    = 1'b0;
        case (state_q)
            S_FETCH_HI: begin
                if (xfer_c) begin
                    inst_d[15:8] = mem_rdata;
                    pc_d         = pc_q + ADDR_W'(1);
                    state_d      = S_FETCH_LO;
                end
            end
            S_FETCH_LO: begin
                if (xfer_c) begin
                    inst_d[7:0] = mem_rdata;
                    pc_d        = pc_q + ADDR_W'(1);
                    state_d     = has_data_c ? S_FETCH_DATA : S_EXEC;
                end
            end
            S_FETCH_DATA: begin
                if (xfer_c) begin
                    data_d  = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!skip_q) begin
                    exec_c = 1'b1;
                    if (inst_branch) begin
                        pc_d = pc_q + rhs;
                    end
                    if (inst_if) begin
                        if (if_zero) begin
                            skip_d = !acc_zero;
                            else_d = !acc_zero;
                        end else if (if_not_zero) begin
                            skip_d = acc_zero;
                            else_d = acc_zero;
                        end else if (if_else) begin
                            skip_d = !else_q;
                        end else if (if_not_else) begin
                            skip_d = else_q;
                        end
                    end
                end else begin
                    skip_d = 1'b0;
                end
`ifdef CPU_SINGLE_STEP_EN
                state_d = S_HALT;
`else
                state_d = S_FETCH_HI;
`endif
            end
`ifdef CPU_SINGLE_STEP_EN
            S_HALT: begin
                if (step) begin
                    state_d = S_FETCH_HI;
                end
            end
`endif
            default: state_d = S_FETCH_HI;
        endcase
        mem_req_d = (state_d == S_FETCH_HI) || (state_d == S_FETCH_LO) ||
                    (state_d == S_FETCH_DATA);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH_HI;
            pc_q      <= '0;
            inst_q    <= '0;
            data_q    <= '0;
            skip_q    <= 1'b0;
            else_q    <= 1'b0;
            mem_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            data_q    <= data_d;
            skip_q    <= skip_d;
            else_q    <= else_d;
            mem_req_q <= mem_req_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign inst     = inst_q;
    assign data     = data_q;
    assign dec_en   = exec_c;
    assign exec     = exec_c;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer with a byte memory and mock decoder.
module tb_cpu_sequencer;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [15:0] inst;
    logic [7:0]  data;
    logic        dec_en;
    logic        exec;
    logic [15:0] pc;
    logic        inst_branch, inst_if;
    logic        if_zero, if_not_zero, if_else, if_not_else;
    logic [15:0] rhs;
    logic        acc_zero;
`ifdef CPU_SINGLE_STEP_EN
    logic        step;
`endif

    logic [7:0]  mem [0:65535];
    int          wait_cycles;
    int          wcnt;
    logic        ack_mode;
    logic        ack_force;
    logic [7:0]  rdata_force;
    int          errors;
    int          checks;

    cpu_sequencer dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .inst(inst), .data(data), .dec_en(dec_en), .exec(exec), .pc(pc),
        .inst_branch(inst_branch), .inst_if(inst_if),
        .if_zero(if_zero), .if_not_zero(if_not_zero), .if_else(if_else), .if_not_else(if_not_else),
        .rhs(rhs), .acc_zero(acc_zero)
`ifdef CPU_SINGLE_STEP_EN
        , .step(step)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: ack after wait_cycles idle cycles, or a forced ack/data
    assign mem_ack   = ack_mode ? ack_force : (mem_req && (wcnt == wait_cycles));
    assign mem_rdata = ack_mode ? rdata_force : mem[mem_addr];
    always @(posedge clk) wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;

    // Mock decoder: 11xx_xxxx branch by sext(inst[7:0]); 0x400n IF with condition n
    always_comb begin
        inst_branch = (inst[15:14] == 2'b11);
        rhs         = inst_branch ? {{8{inst[7]}}, inst[7:0]} : 16'h1234;
        inst_if     = (inst[15:12] == 4'h4);
        if_zero     = inst_if && (inst[2:0] == 3'd1);
        if_not_zero = inst_if && (inst[2:0] == 3'd2);
        if_else     = inst_if && (inst[2:0] == 3'd3);
        if_not_else = inst_if && (inst[2:0] == 3'd4);
    end

    task automatic do_reset();
        rst = 1'b1;
        ack_mode = 1'b0;
        wait_cycles = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Advance to the next negedge with exec high, bounded
    task automatic wait_exec(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (exec !== 1'b1 && cyc < 60);
        if (exec !== 1'b1) begin
            errors++; checks++;
            $display("FAIL wait_exec: exec not seen within %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL rst_pc: got %h want 0000", pc); end
        checks++; if (inst !== 16'h0000) begin errors++; $display("FAIL rst_inst: got %h want 0000", inst); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", data); end
        checks++; if (exec !== 1'b0 || dec_en !== 1'b0) begin errors++; $display("FAIL rst_exec: got %b%b want 00", exec, dec_en); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin errors++; $display("FAIL nop_c1: req %b addr %h want 1 0000", mem_req, mem_addr); end
        @(negedge clk);
        checks++; if (exec !== 1'b0 || mem_addr !== 16'h0001) begin errors++; $display("FAIL nop_c2: exec %b addr %h want 0 0001", exec, mem_addr); end
        @(negedge clk);
        checks++; if (exec !== 1'b1 || dec_en !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL nop_c3: exec %b dec_en %b req %b want 1 1 0", exec, dec_en, mem_req); end
        checks++; if (pc !== 16'h0002) begin errors++; $display("FAIL nop_pc: got %h want 0002", pc); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0002 || exec !== 1'b0) begin errors++; $display("FAIL nop_next: req %b addr %h exec %b want 1 0002 0", mem_req, mem_addr, exec); end
    endtask

    task automatic test_data_operand();
        int cyc;
        mem[0] = 8'h82; mem[1] = 8'h5A; mem[2] = 8'h3C;
        do_reset();
        wait_cycles = 1;
        wait_exec(cyc);
        checks++; if (cyc !== 7) begin errors++; $display("FAIL data_cycles: got %0d want 7", cyc); end
        checks++; if (inst !== 16'h825A) begin errors++; $display("FAIL data_inst: got %h want 825a", inst); end
        checks++; if (data !== 8'h3C) begin errors++; $display("FAIL data_byte: got %h want 3c", data); end
        checks++; if (pc !== 16'h0003) begin errors++; $display("FAIL data_pc: got %h want 0003", pc); end
        @(negedge clk);
        checks++; if (exec !== 1'b0 || mem_addr !== 16'h0003) begin errors++; $display("FAIL data_after: exec %b addr %h want 0 0003", exec, mem_addr); end
        wait_cycles = 0;
    endtask

    task automatic test_branch();
        int cyc;
        mem[0] = 8'hC0; mem[1] = 8'h0E;
        mem[16'h0010] = 8'hC7; mem[16'h0011] = 8'hFE;
        do_reset();
        wait_exec(cyc);
        @(negedge clk);
        checks++; if (mem_addr !== 16'h0010 || mem_req !== 1'b1) begin errors++; $display("FAIL br_fwd: addr %h req %b want 0010 1", mem_addr, mem_req); end
        wait_exec(cyc);
        checks++; if (pc !== 16'h0012) begin errors++; $display("FAIL br_self_pc: got %h want 0012", pc); end
        @(negedge clk);
        checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL br_self: addr %h want 0010", mem_addr); end
        mem[0] = 8'hC0; mem[1] = 8'hFB;
        mem[16'hFFFD] = 8'hC0; mem[16'hFFFE] = 8'h05;
        do_reset();
        wait_exec(cyc);
        @(negedge clk);
        checks++; if (mem_addr !== 16'hFFFD) begin errors++; $display("FAIL br_back: addr %h want fffd", mem_addr); end
        wait_exec(cyc);
        checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL br_hi_pc: got %h want ffff", pc); end
        @(negedge clk);
        checks++; if (mem_addr !== 16'h0004) begin errors++; $display("FAIL br_wrap: addr %h want 0004", mem_addr); end
        mem[0] = 8'hC0; mem[1] = 8'hFC;
        mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h00;
        do_reset();
        wait_exec(cyc);
        wait_exec(cyc);
        checks++; if (pc !== 16'h0000 || inst !== 16'h0000) begin errors++; $display("FAIL fetch_wrap: pc %h inst %h want 0000 0000", pc, inst); end
    endtask

    task automatic test_if_skip();
        int cyc;
        int hits;
        logic [7:0] prog [0:20];
        prog = '{8'h40, 8'h01, 8'hC0, 8'h10, 8'h40, 8'h03, 8'h00, 8'h00,
                 8'h40, 8'h02, 8'h82, 8'h01, 8'h77, 8'h40, 8'h04, 8'h00,
                 8'h00, 8'h40, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 21; i++) mem[i] = prog[i];
        acc_zero = 1'b0;
        do_reset();
        wait_exec(cyc);
        checks++; if (inst !== 16'h4001) begin errors++; $display("FAIL ifz_inst: got %h want 4001", inst); end
        hits = 0;
        repeat (3) begin @(negedge clk); if (exec === 1'b1 || dec_en === 1'b1) hits++; end
        checks++; if (hits !== 0) begin errors++; $display("FAIL skip_br_exec: got %0d exec cycles want 0", hits); end
        checks++; if (pc !== 16'h0004 || inst !== 16'hC010) begin errors++; $display("FAIL skip_br_pc: pc %h inst %h want 0004 c010", pc, inst); end
        wait_exec(cyc);
        checks++; if (inst !== 16'h4003 || cyc !== 3) begin errors++; $display("FAIL ifelse_exec: inst %h cyc %0d want 4003 3", inst, cyc); end
        wait_exec(cyc);
        checks++; if (pc !== 16'h0008 || cyc !== 3) begin errors++; $display("FAIL after_else: pc %h cyc %0d want 0008 3", pc, cyc); end
        acc_zero = 1'b1;
        wait_exec(cyc);
        checks++; if (inst !== 16'h4002) begin errors++; $display("FAIL ifnz_inst: got %h want 4002", inst); end
        hits = 0;
        repeat (4) begin @(negedge clk); if (exec === 1'b1) hits++; end
        checks++; if (hits !== 0 || data !== 8'h77 || pc !== 16'h000D) begin errors++; $display("FAIL skip_data: exec %0d data %h pc %h want 0 77 000d", hits, data, pc); end
        wait_exec(cyc);
        checks++; if (inst !== 16'h4004 || cyc !== 3) begin errors++; $display("FAIL ifne_exec: inst %h cyc %0d want 4004 3", inst, cyc); end
        wait_exec(cyc);
        checks++; if (inst !== 16'h4000 || pc !== 16'h0013) begin errors++; $display("FAIL skip_nop: inst %h pc %h want 4000 0013", inst, pc); end
        wait_exec(cyc);
        checks++; if (pc !== 16'h0015 || cyc !== 3 || data !== 8'h77) begin errors++; $display("FAIL nocond: pc %h cyc %0d data %h want 0015 3 77", pc, cyc, data); end
    endtask

    task automatic test_reset_mid_fetch();
        mem[0] = 8'h12; mem[1] = 8'h34;
        do_reset();
        ack_mode = 1'b1; ack_force = 1'b0; rdata_force = 8'h12;
        @(negedge clk);
        ack_force = 1'b1;
        @(negedge clk);
        checks++; if (inst !== 16'h1200 || pc !== 16'h0001) begin errors++; $display("FAIL mid_pre: inst %h pc %h want 1200 0001", inst, pc); end
        rdata_force = 8'h34;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0 || pc !== 16'h0000 || inst !== 16'h0000) begin errors++; $display("FAIL mid_rst: req %b pc %h inst %h want 0 0000 0000", mem_req, pc, inst); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (inst !== 16'h0000 || pc !== 16'h0000 || mem_req !== 1'b1) begin errors++; $display("FAIL late_ack: inst %h pc %h req %b want 0000 0000 1", inst, pc, mem_req); end
        ack_mode = 1'b0;
    endtask

`ifdef CPU_SINGLE_STEP_EN
    task automatic test_single_step();
        int cyc;
        int bad;
        mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
        step = 1'b0;
        do_reset();
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_exec(cyc);
        checks++; if (cyc !== 1 || pc !== 16'h0002) begin errors++; $display("FAIL step_ignored: cyc %0d pc %h want 1 0002", cyc, pc); end
        bad = 0;
        repeat (10) begin @(negedge clk); if (mem_req !== 1'b0) bad++; end
        checks++; if (bad !== 0) begin errors++; $display("FAIL halt_hold: %0d cycles with req want 0", bad); end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0002) begin errors++; $display("FAIL step_go: req %b addr %h want 1 0002", mem_req, mem_addr); end
        wait_exec(cyc);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL step_exec: cyc %0d want 2", cyc); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rehalt: req %b want 0", mem_req); end
    endtask
`endif

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; acc_zero = 1'b0;
        ack_mode = 1'b0; ack_force = 1'b0; rdata_force = 8'h00; wait_cycles = 0;
`ifdef CPU_SINGLE_STEP_EN
        step = 1'b0;
`endif
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        test_reset();
`ifdef CPU_SINGLE_STEP_EN
        test_single_step();
`else
        test_data_operand();
        test_branch();
        test_if_skip();
        test_reset_mid_fetch();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
